// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-side memory port arbiter.
package mem_arb_pkg;

    localparam int N_CORES = 4;
    localparam int IDX_W   = $clog2(N_CORES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT,
        ACK
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_CORES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first requesting core at or after pointer p.
module rr_pick #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IDX_W-1:0]   p,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    // Walk p, p+1, ... ; index arithmetic wraps in IDX_W bits (N_CORES is a power of two)
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        grant   = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            idx = p + IDX_W'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving four cores serialized access to one data memory port.
// Stores are 16-bit little-endian, loads return one byte from the registered read port.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int N_CORES    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CORES-1:0]              req,
    input  logic [N_CORES-1:0]              wr,
    input  logic [N_CORES*ADDR_WIDTH-1:0]   addr,
    input  logic [N_CORES*2*DATA_WIDTH-1:0] wdata,
    output logic [N_CORES-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_w_addr,
    output logic [2*DATA_WIDTH-1:0]         mem_w_data,
    output logic [ADDR_WIDTH-1:0]           mem_r_addr,
    input  logic [DATA_WIDTH-1:0]           mem_r_data
);

    import mem_arb_pkg::*;

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        p;
    logic [IDX_W-1:0]        g;
    logic [IDX_W-1:0]        pick;
    logic                    any_req;
    logic                    op_wr;
    logic                    grant_now;
    logic                    busy_d;
    logic [N_CORES-1:0]      ack_d;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [2*DATA_WIDTH-1:0] sel_wdata;

    rr_pick #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .p       (p),
        .grant   (pick),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: grant in IDLE, loads take an extra cycle for the read register
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = op_wr ? ACK : RDWAIT;
            RDWAIT:  next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: next-cycle values that the output registers load
    always_comb begin
        grant_now = (state == IDLE) && any_req;
        busy_d    = (next_state != IDLE);
        ack_d     = '0;
        if (next_state == ACK) begin
            ack_d = idx_onehot(g);
        end
        sel_addr  = addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[int'(pick)*2*DATA_WIDTH +: 2*DATA_WIDTH];
    end

    // Registered outputs, grant bookkeeping and load capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p          <= '0;
            g          <= '0;
            op_wr      <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            mem_r_addr <= '0;
            rdata      <= '0;
        end else begin
            ack    <= ack_d;
            busy   <= busy_d;
            mem_we <= 1'b0;
            if (grant_now) begin
                g          <= pick;
                p          <= pick + IDX_W'(1);
                op_wr      <= wr[pick];
                mem_we     <= wr[pick];
                mem_w_addr <= sel_addr;
                mem_w_data <= sel_wdata;
                mem_r_addr <= sel_addr;
            end
            if (state == RDWAIT) begin
                rdata <= mem_r_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a transaction-level reference arbiter and memory.
module tb_mem_port_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req   = '0;
    logic [3:0]  wr    = '0;
    logic [31:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic        mem_we;
    logic [7:0]  mem_w_addr;
    logic [15:0] mem_w_data;
    logic [7:0]  mem_r_addr;
    logic [7:0]  mem_r_data = '0;
    logic [7:0]  w_hi;

    mem_port_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .N_CORES    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  rdata;
        int          ack_cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] data;
    } st_t;

    exp_t        exp_q[$];
    st_t         st_q[$];
    logic [31:0] ack_log[$];
    logic [7:0]  phys_mem [256];
    logic [7:0]  ref_mem  [256];

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          free_at   = 0;
    int          busy_end  = -1;
    int          rp        = 0;
    bit          pw_valid  = 1'b0;
    int          pw_cyc    = 0;
    logic [7:0]  pw_addr   = '0;
    logic [15:0] pw_data   = '0;
    logic [7:0]  exp_rdata = '0;

    logic [3:0]  auto_mask = '0;
    int unsigned auto_prob = 0;
    int unsigned store_pct = 50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Memory behind the port: byte-wide, store writes addr and addr+1 (8-bit wrap), registered read
    assign w_hi = mem_w_addr + 8'd1;
    always @(posedge clk) begin
        if (mem_we) begin
            phys_mem[mem_w_addr] <= mem_w_data[7:0];
            phys_mem[w_hi]       <= mem_w_data[15:8];
        end
        mem_r_data <= phys_mem[mem_r_addr];
    end

    // Reference arbiter: one grant per free slot, round robin from rp, fixed op latencies
    always @(posedge clk) begin
        exp_t       e;
        st_t        s;
        int         g;
        logic [7:0] hi;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            st_q.delete();
            pw_valid = 1'b0;
            rp       = 0;
            free_at  = 0;
            busy_end = -1;
        end else begin
            if (pw_valid && cyc == pw_cyc) begin
                hi           = pw_addr + 8'd1;
                ref_mem[pw_addr] = pw_data[7:0];
                ref_mem[hi]      = pw_data[15:8];
                pw_valid     = 1'b0;
            end
            if (cyc >= free_at && req != '0) begin
                g = -1;
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req[(rp + k) % 4]) g = (rp + k) % 4;
                end
                e.core    = g;
                e.wr      = wr[g];
                e.addr    = addr[g*8 +: 8];
                e.wdata   = wdata[g*16 +: 16];
                e.rdata   = ref_mem[e.addr];
                e.ack_cyc = cyc + (e.wr ? 1 : 2);
                if (e.wr) begin
                    s.cyc    = cyc;
                    s.addr   = e.addr;
                    s.data   = e.wdata;
                    st_q.push_back(s);
                    pw_valid = 1'b1;
                    pw_cyc   = cyc + 1;
                    pw_addr  = e.addr;
                    pw_data  = e.wdata;
                end
                exp_q.push_back(e);
                rp       = (g + 1) % 4;
                busy_end = e.ack_cyc;
                free_at  = e.ack_cyc + 2;
            end
        end
    end

    // Monitor: compare every DUT output event against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        st_t  s;
        if (!rst_n) exp_rdata = '0;
        if (exp_q.size() != 0 && exp_q[0].ack_cyc < cyc) begin
            check("ack_missing_cycle", 32'(cyc), 32'(exp_q[0].ack_cyc));
            void'(exp_q.pop_front());
        end
        if (st_q.size() != 0 && st_q[0].cyc < cyc) begin
            check("we_missing_cycle", 32'(cyc), 32'(st_q[0].cyc));
            void'(st_q.pop_front());
        end
        if (ack != '0) begin
            ack_log.push_back(32'(ack));
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("ack_vec", 32'(ack), 32'(4'b0001 << e.core));
                check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                if (!e.wr) begin
                    check("ack_rdata", 32'(rdata), 32'(e.rdata));
                    exp_rdata = e.rdata;
                end
            end
        end
        if (mem_we) begin
            if (st_q.size() == 0) begin
                check("we_unexpected", 32'(mem_we), 32'(0));
            end else begin
                s = st_q.pop_front();
                check("we_cycle", 32'(cyc), 32'(s.cyc));
                check("w_addr", 32'(mem_w_addr), 32'(s.addr));
                check("w_data", 32'(mem_w_data), 32'(s.data));
            end
        end
        check("rdata_hold", 32'(rdata), 32'(exp_rdata));
        check("busy", 32'(busy), 32'(cyc <= busy_end));
    end

    task automatic issue(input int c, input bit w, input logic [7:0] a, input logic [15:0] d);
        req[c]          = 1'b1;
        wr[c]           = w;
        addr[c*8 +: 8]  = a;
        wdata[c*16 +: 16] = d;
    endtask

    // One cycle of core behaviour: drop req after ack, optionally raise a new random request
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (req[i] && ack[i]) req[i] = 1'b0;
            if (auto_mask[i] && !req[i] && $urandom_range(99) < auto_prob)
                issue(i, $urandom_range(99) < store_pct, 8'($urandom), 16'($urandom));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(req == '0 && exp_q.size() == 0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'(1));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int bad;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] b;
            b           = 8'($urandom);
            phys_mem[a] = b;
            ref_mem[a]  = b;
        end
        for (int a = 0; a < 4; a++) begin
            phys_mem[8'h40 + a] = 8'(8'hC0 + a);
            ref_mem[8'h40 + a]  = 8'(8'hC0 + a);
        end
        phys_mem[8'h20] = 8'h5A;
        ref_mem[8'h20]  = 8'h5A;

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_we", 32'(mem_we), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_w_addr", 32'(mem_w_addr), 32'(0));
        check("rst_w_data", 32'(mem_w_data), 32'(0));
        check("rst_r_addr", 32'(mem_r_addr), 32'(0));

        // single store from core 2
        issue(2, 1'b1, 8'h10, 16'hBEEF);
        wait_idle(20);
        check("store_lo", 32'(phys_mem[8'h10]), 32'(8'hEF));
        check("store_hi", 32'(phys_mem[8'h11]), 32'(8'hBE));

        // single load from core 0
        issue(0, 1'b0, 8'h20, 16'h0000);
        wait_idle(20);
        check("load_rdata", 32'(rdata), 32'(8'h5A));

        // all four cores load at once straight out of reset
        apply_reset();
        ack_log.delete();
        for (int c = 0; c < 4; c++) issue(c, 1'b0, 8'(8'h40 + c), 16'h0000);
        wait_idle(40);
        check("contend_count", 32'(ack_log.size()), 32'(4));
        for (int i = 0; i < 4; i++) check("contend_order", ack_log[i], 32'(4'b0001 << i));
        check("contend_last_byte", 32'(rdata), 32'(8'hC3));

        // pointer back at 0: core 0 beats core 3
        ack_log.delete();
        issue(3, 1'b0, 8'h41, 16'h0000);
        issue(0, 1'b0, 8'h42, 16'h0000);
        wait_idle(30);
        check("ptr_wrap_first", ack_log[0], 32'(4'b0001));

        // cores 1 and 3 re-request continuously
        ack_log.delete();
        auto_mask = 4'b1010;
        auto_prob = 100;
        repeat (40) tick();
        auto_mask = '0;
        wait_idle(30);
        check("fair_count", 32'(ack_log.size() >= 8), 32'(1));
        for (int i = 0; i < ack_log.size(); i++)
            check("fair_order", ack_log[i], (i % 2 == 0) ? 32'(4'b0010) : 32'(4'b1000));

        // store to the top address wraps its high byte
        issue(1, 1'b1, 8'hFF, 16'h1234);
        wait_idle(20);
        check("wrap_hi_addr", 32'(phys_mem[8'hFF]), 32'(8'h34));
        check("wrap_lo_addr", 32'(phys_mem[8'h00]), 32'(8'h12));

        // reset while a store is in ISSUE
        ack_log.delete();
        issue(1, 1'b1, 8'h33, 16'hA5C3);
        tick();
        check("mid_we_issue", 32'(mem_we), 32'(1));
        #1 rst_n = 1'b0;
        req = '0;
        #1;
        check("mid_we_drop", 32'(mem_we), 32'(0));
        check("mid_ack", 32'(ack), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("mid_no_ack", 32'(ack_log.size()), 32'(0));
        issue(3, 1'b0, 8'h21, 16'h0000);
        issue(0, 1'b0, 8'h20, 16'h0000);
        wait_idle(30);
        check("post_rst_first", ack_log[0], 32'(4'b0001));
        check("post_rst_count", 32'(ack_log.size()), 32'(2));

        // random traffic on all cores
        auto_mask = 4'b1111;
        auto_prob = 30;
        store_pct = 50;
        repeat (600) tick();
        auto_mask = '0;
        wait_idle(60);

        bad = 0;
        for (int a = 0; a < 256; a++) if (phys_mem[a] !== ref_mem[a]) bad++;
        check("mem_image", 32'(bad), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Core-side initiator for the shared data memory. It accepts load and store requests from four processing cores over a req/ack handshake and grants one core at a time in round-robin order. For the granted core it drives a single memory port: 16-bit little-endian store, 8-bit registered load. It returns the load byte and a one-cycle ack to the requester, and sits between the core array and the data memory in the multi-core multiplier top level.

## Interface
Parameters:
- DATA_WIDTH, 8, memory byte width; store word is 2*DATA_WIDTH
- ADDR_WIDTH, 8, memory address width
- N_CORES, 4, requester count; fixed at 4 in this revision

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_CORES  per-core request, held until ack
- wr  in  N_CORES  per-core op: 1 = store, 0 = load; valid with req
- addr  in  N_CORES*ADDR_WIDTH  flat; core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  N_CORES*2*DATA_WIDTH  flat; core i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
- ack  out  N_CORES  one-hot, one-cycle completion pulse
- rdata  out  DATA_WIDTH  load result; valid while ack is high for a load
- busy  out  1  high whenever the FSM is not in IDLE
- mem_we  out  1  memory write enable
- mem_w_addr  out  ADDR_WIDTH  store address
- mem_w_data  out  2*DATA_WIDTH  store word: [7:0] goes to addr, [15:8] goes to addr+1
- mem_r_addr  out  ADDR_WIDTH  load address
- mem_r_data  in  DATA_WIDTH  memory read register; valid the cycle after mem_r_addr is presented with mem_we low

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- IDLE: if any req bit is high, the round-robin pick registers the grant index, the op, the address and the data. All mem_* outputs are loaded, with mem_we = wr[g]. Next state is ISSUE. With no request, the FSM stays in IDLE.
- ISSUE: the memory port is driven for exactly one cycle. For a store, the next state is ACK. For a load, the next state is RDWAIT. mem_we clears on leaving ISSUE.
- RDWAIT: mem_r_data is captured into rdata at the end of the cycle. Next state is ACK.
- ACK: ack[g] = 1 for one cycle. Next state is IDLE. rdata holds its value until the next load capture; stores leave rdata unchanged.
- Round robin: pointer p starts at 0. Search order is p, p+1, … mod N_CORES. After a grant to g, p ← (g+1) mod N_CORES.
- Requester rule: req, wr, addr and wdata stay stable from assertion until ack. The core drops req on the edge that ends its ack cycle. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait. There is no queueing beyond the req lines, and no request is lost.
- Address arithmetic: addresses pass through unchanged. The store to addr = 2^ADDR_WIDTH−1 wraps its high byte to address 0; this is memory-side behaviour, and the arbiter imposes no restriction on it.
- Reset (asynchronous, any state): FSM → IDLE, p → 0, ack → 0, busy → 0, mem_we → 0, rdata → 0, and mem_w_addr, mem_w_data, mem_r_addr → 0. An in-flight store is aborted and no ack is issued. Cores must re-request after reset.

## Timing
- Request first seen high in IDLE at edge t.
- Store: mem_we high during cycle t+1 (ISSUE). Memory written at edge t+2. ack high during cycle t+2.
- Load: mem_r_addr valid from cycle t+1. mem_r_data valid during t+2. ack and rdata valid during t+3.
- Throughput per grant: 3 cycles for a store (IDLE, ISSUE, ACK) and 4 cycles for a load.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous requests from all four cores are served in pointer order, back to back. IDLE lasts one cycle between grants.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE, ISSUE, RDWAIT, ACK), N_CORES and the grant-index width localparam.
- Sub-module rr_pick holds the combinational rotate-priority encoder. Inputs are req and p; outputs are the grant index and any_req. The pointer register lives in the parent.

## Test plan
- Single store: core 2 requests with addr = 0x10 and wdata = 0xBEEF. Required: mem_we for exactly one cycle with w_addr = 0x10 and w_data = 0xBEEF, ack = 4'b0100 two cycles after the request, memory[0x10] = 0xEF and memory[0x11] = 0xBE.
- Single load: memory[0x20] is preloaded with 0x5A and core 0 loads addr 0x20. Required: ack = 4'b0001 three cycles after the request and rdata = 0x5A in that cycle.
- Contention: all four cores request loads in the same cycle from reset. Required: acks in order 0, 1, 2, 3, spaced 4 cycles apart, each with its own byte, and p = 0 afterwards.
- Fairness: cores 1 and 3 keep re-requesting. Required: grants alternate 1, 3, 1, 3 and no core is starved.
- Wrap: core 1 stores 0x1234 to addr 0xFF. Required: mem_w_addr = 0xFF and mem_w_data = 0x1234 are passed unchanged, memory[0xFF] = 0x34 and memory[0x00] = 0x12.
- Reset mid-op: rst_n is pulled low during ISSUE of a store. Required: mem_we drops immediately with no ack and the FSM is in IDLE. A request after rst_n rises completes normally with the pointer starting at 0.
